mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, owner
// codes, port identifiers and the default burst limit.
package mem_arbiter_pkg;

  // State values double as the debug owner code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  localparam int unsigned DEFAULT_MAX_BEATS = 8;

  function automatic logic [1:0] owner_code(input state_e s);
    case (s)
      OWN0:    return OWNER_P0;
      OWN1:    return OWNER_P1;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-cycle memory between the
// instruction cache (port 0) and the data cache (port 1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BEATS = DEFAULT_MAX_BEATS,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_ce,
  input  logic              p0_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_hold,
  input  logic              p1_ce,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_hold,
  output logic              mem_ce,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int unsigned       BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

  state_e            state_q, state_d;
  port_e             last_q, last_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              own_ce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= PORT1;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Owner keeps the bus while its ce is high, unless the other side has
  // waited through a full MAX_BEATS tenure.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (p0_ce && p1_ce)  state_d = (last_q == PORT1) ? OWN0 : OWN1;
        else if (p0_ce)      state_d = OWN0;
        else if (p1_ce)      state_d = OWN1;
      end
      OWN0: begin
        if (!p0_ce)                            state_d = p1_ce ? OWN1 : IDLE;
        else if (p1_ce && beat_q == BEAT_LAST) state_d = OWN1;
      end
      OWN1: begin
        if (!p1_ce)                            state_d = p0_ce ? OWN0 : IDLE;
        else if (p0_ce && beat_q == BEAT_LAST) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign own_ce = ((state_q == OWN0) && p0_ce) || ((state_q == OWN1) && p1_ce);

  always_comb begin
    beat_d = beat_q;
    last_d = last_q;
    if (state_d != state_q) begin
      beat_d = '0;
      if (state_d == OWN0)      last_d = PORT0;
      else if (state_d == OWN1) last_d = PORT1;
    end else if (own_ce && (beat_q != BEAT_LAST)) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_comb begin
    mem_ce    = 1'b0;
    mem_rw    = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      OWN0: begin
        mem_ce    = p0_ce;
        mem_rw    = p0_rw;
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
      end
      OWN1: begin
        mem_ce    = p1_ce;
        mem_rw    = p1_rw;
        mem_addr  = p1_addr;
        mem_wdata = p1_wdata;
      end
      default: ;
    endcase
  end

  assign p0_hold  = p0_ce && (state_q != OWN0);
  assign p1_hold  = p1_ce && (state_q != OWN1);
  assign p0_rdata = ((state_q == OWN0) && p0_ce && p0_rw) ? mem_rdata : '0;
  assign p1_rdata = ((state_q == OWN1) && p1_ce && p1_rw) ? mem_rdata : '0;
  assign owner    = owner_code(state_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a cycle-level
// ownership model built from the arbitration rules.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          p0_ce = 1'b0, p0_rw = 1'b1, p1_ce = 1'b0, p1_rw = 1'b1;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          p0_hold, p1_hold, mem_ce, mem_rw;
  logic [1:0]    owner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BEATS(MAXB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst_n),
    .p0_ce(p0_ce), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_hold(p0_hold),
    .p1_ce(p1_ce), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_hold(p1_hold),
    .mem_ce(mem_ce), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // Reference model: owner 0 = nobody, 1 = port 0, 2 = port 1; m_beats counts
  // cycles the current owner has already used with its ce high.
  int m_owner = 0;
  int m_last  = 2;
  int m_beats = 0;
  int nxt_owner;

  function automatic int next_owner(input int own, input int last, input int beats,
                                    input logic c0, input logic c1);
    int   other;
    logic mine, theirs;
    if (own == 0) begin
      if (c0 && c1) return (last == 1) ? 2 : 1;
      if (c0) return 1;
      if (c1) return 2;
      return 0;
    end
    other  = (own == 1) ? 2 : 1;
    mine   = (own == 1) ? c0 : c1;
    theirs = (own == 1) ? c1 : c0;
    if (!mine) return theirs ? other : 0;
    if (theirs && (beats + 1 >= MAXB)) return other;
    return own;
  endfunction

  always_comb nxt_owner = next_owner(m_owner, m_last, m_beats, p0_ce, p1_ce);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0;
      m_last  <= 2;
      m_beats <= 0;
    end else begin
      m_owner <= nxt_owner;
      if (nxt_owner != m_owner) begin
        m_beats <= 0;
        if (nxt_owner != 0) m_last <= nxt_owner;
      end else if ((m_owner == 1 && p0_ce) || (m_owner == 2 && p1_ce)) begin
        m_beats <= m_beats + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic          ece, erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, er0, er1;
    ece = 1'b0; erw = 1'b1; ea = '0; ed = '0;
    if (m_owner == 1) begin
      ece = p0_ce; erw = p0_rw; ea = p0_addr; ed = p0_wdata;
    end else if (m_owner == 2) begin
      ece = p1_ce; erw = p1_rw; ea = p1_addr; ed = p1_wdata;
    end
    er0 = (m_owner == 1 && p0_ce && p0_rw) ? mem_rdata : '0;
    er1 = (m_owner == 2 && p1_ce && p1_rw) ? mem_rdata : '0;
    chk("owner",     64'(owner),     64'(m_owner));
    chk("p0_hold",   64'(p0_hold),   64'(p0_ce && m_owner != 1));
    chk("p1_hold",   64'(p1_hold),   64'(p1_ce && m_owner != 2));
    chk("mem_ce",    64'(mem_ce),    64'(ece));
    chk("mem_rw",    64'(mem_rw),    64'(erw));
    chk("mem_addr",  64'(mem_addr),  64'(ea));
    chk("mem_wdata", 64'(mem_wdata), 64'(ed));
    chk("p0_rdata",  64'(p0_rdata),  64'(er0));
    chk("p1_rdata",  64'(p1_rdata),  64'(er1));
  endtask

  task automatic apply(input logic r,
                       input logic c0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0,
                       input logic c1, input logic w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1);
    @(negedge clk);
    rst_n = r;
    p0_ce = c0; p0_rw = w0; p0_addr = a0; p0_wdata = d0;
    p1_ce = c1; p1_rw = w1; p1_addr = a1; p1_wdata = d1;
    mem_rdata = DW'($urandom);
    #1;
    check_all();
  endtask

  task automatic idle(input logic r);
    apply(r, 1'b0, 1'b1, '0, '0, 1'b0, 1'b1, '0, '0);
  endtask

  int k, granted, rem0, rem1, run1, max_run, g_tot1, prev_g, cnt0, cnt1, g;
  bit started0;

  initial begin
    #2 rst_n = 1'b0;

    // Reset state
    idle(1'b0);
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_mem_ce", 64'(mem_ce), 64'(0));
    chk("rst_mem_rw", 64'(mem_rw), 64'(1));
    idle(1'b0);
    idle(1'b1);

    // Port 0 line fill of eight words
    k = 0; granted = 0;
    for (int i = 0; i < 20 && granted < 8; i++) begin
      apply(1'b1, 1'b1, 1'b1, AW'(32'h100 + 4 * k), '0, 1'b0, 1'b1, '0, '0);
      if (i == 0) begin
        chk("fill_first_hold", 64'(p0_hold), 64'(1));
      end else begin
        chk("fill_owner", 64'(owner), 64'(2'b01));
        chk("fill_addr", 64'(mem_addr), 64'(32'h100 + 4 * k));
        chk("fill_p1_hold", 64'(p1_hold), 64'(0));
      end
      if (m_owner == 1) begin granted++; k++; end
    end
    chk("fill_beats", 64'(granted), 64'(8));
    idle(1'b1);

    // Simultaneous requests straight after reset: port 0 wins, no IDLE bubble
    idle(1'b0);
    apply(1'b1, 1'b1, 1'b1, 32'h200, '0, 1'b1, 1'b1, 32'h300, '0);
    chk("tie_idle_owner", 64'(owner), 64'(0));
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 1'b1, 32'h200, '0, 1'b1, 1'b1, 32'h300, '0);
      chk("tie_owner0", 64'(owner), 64'(2'b01));
      chk("tie_p1_hold", 64'(p1_hold), 64'(1));
    end
    apply(1'b1, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 32'h300, '0);
    apply(1'b1, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 32'h300, '0);
    chk("tie_direct_owner1", 64'(owner), 64'(2'b10));
    idle(1'b1);
    idle(1'b1);

    // Port 1 wants 12 beats; port 0 joins after two and preempts at 8
    rem1 = 12; rem0 = 0; started0 = 0; run1 = 0; max_run = 0; g_tot1 = 0;
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, rem0 > 0, 1'b1, 32'h500, '0, rem1 > 0, 1'b1, 32'h600, '0);
      if (m_owner == 2 && p1_ce) begin
        rem1--; g_tot1++; run1++;
        if (run1 > max_run) max_run = run1;
      end else begin
        run1 = 0;
      end
      if (m_owner == 1 && p0_ce) rem0--;
      if (g_tot1 == 2 && !started0) begin rem0 = 3; started0 = 1; end
      if (started0 && rem0 == 0 && rem1 == 0) break;
    end
    chk("preempt_run", 64'(max_run), 64'(MAXB));
    chk("preempt_p1_done", 64'(rem1), 64'(0));
    chk("preempt_p0_done", 64'(rem0), 64'(0));
    idle(1'b1);

    // Single port 1 write
    apply(1'b1, 1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    apply(1'b1, 1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    chk("wr_mem_ce", 64'(mem_ce), 64'(1));
    chk("wr_mem_rw", 64'(mem_rw), 64'(0));
    chk("wr_mem_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
    chk("wr_mem_addr", 64'(mem_addr), 64'(32'h40));
    chk("wr_p0_rdata", 64'(p0_rdata), 64'(0));
    idle(1'b1);
    chk("wr_after_ce", 64'(mem_ce), 64'(0));

    // Reset in the 4th beat of a port 0 burst
    apply(1'b1, 1'b1, 1'b1, 32'h700, '0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 3; i++)
      apply(1'b1, 1'b1, 1'b1, AW'(32'h700 + 4 * i), '0, 1'b1, 1'b1, 32'h800, '0);
    apply(1'b0, 1'b1, 1'b1, 32'h70C, '0, 1'b1, 1'b1, 32'h800, '0);
    chk("rstmid_owner", 64'(owner), 64'(0));
    chk("rstmid_mem_ce", 64'(mem_ce), 64'(0));
    apply(1'b0, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 32'h800, '0);
    chk("rstmid_hold_ce", 64'(mem_ce), 64'(0));
    apply(1'b1, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 32'h800, '0);
    chk("rstrel_idle", 64'(owner), 64'(0));
    apply(1'b1, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 32'h800, '0);
    chk("rstrel_p1_granted", 64'(owner), 64'(2'b10));
    idle(1'b1);
    idle(1'b1);

    // Alternating single-beat requests
    rem0 = 1; rem1 = 1; prev_g = 0; cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 100; i++) begin
      apply(1'b1, rem0 > 0, 1'b1, 32'hA00, '0, rem1 > 0, 1'b1, 32'hB00, '0);
      g = 0;
      if (m_owner == 1 && p0_ce) g = 1;
      if (m_owner == 2 && p1_ce) g = 2;
      if (g != 0) begin
        if (prev_g != 0) chk("alt_order", 64'(g), 64'(3 - prev_g));
        prev_g = g;
        if (g == 1) cnt0++; else cnt1++;
      end
      if (g == 1) rem0 = 0; else if (rem0 == 0) rem0 = 1;
      if (g == 2) rem1 = 0; else if (rem1 == 0) rem1 = 1;
    end
    chk("alt_p0_served", 64'(cnt0 >= 20), 64'(1));
    chk("alt_p1_served", 64'(cnt1 >= 20), 64'(1));
    idle(1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 59) != 0,
            $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), DW'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
